// File: rtl/pic_core_pkg.sv
// pic_core_pkg: opcode constants, FSM/ALU enums and the 8-bit ALU shared by the core.
// Rev 1.0
`default_nettype none

package pic_core_pkg;

  localparam logic [5:0] OP_MOVLW  = 6'b110000;
  localparam logic [5:0] OP_ADDLW  = 6'b111110;
  localparam logic [5:0] OP_SUBLW  = 6'b111100;
  localparam logic [5:0] OP_ANDLW  = 6'b111001;
  localparam logic [5:0] OP_IORLW  = 6'b111000;
  localparam logic [5:0] OP_XORLW  = 6'b111010;
  localparam logic [5:0] OP_RETLW  = 6'b110100;
  localparam logic [5:0] OP_ADDWF  = 6'b000111;
  localparam logic [5:0] OP_ANDWF  = 6'b000101;
  localparam logic [5:0] OP_COMF   = 6'b001001;
  localparam logic [5:0] OP_DECF   = 6'b000011;
  localparam logic [5:0] OP_INCF   = 6'b001010;
  localparam logic [5:0] OP_MOVF   = 6'b001000;
  localparam logic [5:0] OP_DECFSZ = 6'b001011;
  localparam logic [5:0] OP_INCFSZ = 6'b001111;

  localparam logic [6:0]  OP7_CLRF    = 7'b0000011;
  localparam logic [6:0]  OP7_CLRW    = 7'b0000010;
  localparam logic [6:0]  OP7_MOVWF   = 7'b0000001;
  localparam logic [13:0] INSN_RETURN = 14'h0008;
  localparam logic [2:0]  OP3_GOTO    = 3'b101;
  localparam logic [2:0]  OP3_CALL    = 3'b100;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_IOR, ALU_XOR,
    ALU_PASS, ALU_INC, ALU_DEC, ALU_CLR, ALU_COM
  } alu_op_t;

  // Bit 8 carries C: carry-out for ADD, not-borrow for SUB (a - w).
  function automatic logic [8:0] alu_eval(alu_op_t op, logic [7:0] a, logic [7:0] w);
    logic [8:0] r;
    r = 9'd0;
    case (op)
      ALU_ADD: r = {1'b0, a} + {1'b0, w};
      ALU_SUB: begin
        r    = {1'b0, a} - {1'b0, w};
        r[8] = ~r[8];
      end
      ALU_AND: r = {1'b0, a & w};
      ALU_IOR: r = {1'b0, a | w};
      ALU_XOR: r = {1'b0, a ^ w};
      ALU_INC: r = {1'b0, a + 8'd1};
      ALU_DEC: r = {1'b0, a - 8'd1};
      ALU_CLR: r = 9'd0;
      ALU_COM: r = {1'b0, ~a};
      default: r = {1'b0, a};
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pic_core_stack_if.sv
// pic_core_stack_if: program-memory port and system output bus of the core.
// Rev 1.0
`default_nettype none

interface pic_core_stack_if #(parameter int PC_W = 11);
  logic [PC_W-1:0] imem_addr;
  logic [13:0]     imem_data;
  logic [7:0]      w_q_out;
  logic            status_z;
  logic            status_c;
  logic            retire;
  logic            stk_err;
  logic            halted;

  modport core (
    output imem_addr, w_q_out, status_z, status_c, retire, stk_err, halted,
    input  imem_data
  );

  modport sys (
    input  imem_addr, w_q_out, status_z, status_c, retire, stk_err, halted,
    output imem_data
  );
endinterface

`default_nettype wire

// File: rtl/pic_call_stack.sv
// pic_call_stack: return-address LIFO. PIC_CORE_STKERR_EN flags and blocks
// overflow/underflow; otherwise the pointer wraps mod STACK_DEPTH. Rev 1.0
`default_nettype none

module pic_call_stack #(
  parameter int STACK_DEPTH = 8,
  parameter int PC_W        = 11
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] dout,
  output logic            ovf,
  output logic            unf
);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);

  logic [PC_W-1:0] r_mem [STACK_DEPTH];
  logic [SP_W-1:0] r_sp;
  logic [SP_W-1:0] w_sp_inc;
  logic [SP_W-1:0] w_sp_dec;
  logic            w_do_push;
  logic            w_do_pop;

`ifdef PIC_CORE_STKERR_EN
  localparam logic [SP_W-1:0] c_top = SP_W'(STACK_DEPTH);
  assign ovf      = push && (r_sp == c_top);
  assign unf      = pop && (r_sp == '0);
  assign w_sp_inc = r_sp + SP_W'(1);
  assign w_sp_dec = r_sp - SP_W'(1);
`else
  localparam logic [SP_W-1:0] c_last = SP_W'(STACK_DEPTH - 1);
  assign ovf      = 1'b0;
  assign unf      = 1'b0;
  assign w_sp_inc = (r_sp == c_last) ? '0 : r_sp + SP_W'(1);
  assign w_sp_dec = (r_sp == '0) ? c_last : r_sp - SP_W'(1);
`endif

  assign w_do_push = push && !ovf;
  assign w_do_pop  = pop && !unf;
  assign dout      = r_mem[w_sp_dec[IDX_W-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sp <= '0;
    end else if (w_do_push) begin
      r_sp <= w_sp_inc;
    end else if (w_do_pop) begin
      r_sp <= w_sp_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_sp[IDX_W-1:0]] <= din;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pic_core_stack.sv
// pic_core_stack: two-state FETCH/EXEC 14-bit-instruction core with call stack.
// Optional PIC_CORE_STKERR_EN: stack faults set stk_err/halted and stop the core. Rev 1.0
`default_nettype none

module pic_core_stack
  import pic_core_pkg::*;
#(
  parameter int PC_W        = 11,
  parameter int RAM_AW      = 7,
  parameter int STACK_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  pic_core_stack_if.core        pbus
);
  localparam int RAM_DEPTH = 2 ** RAM_AW;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [13:0]     r_ir;
  logic [7:0]      r_w;
  logic            r_z;
  logic            r_c;
  logic            r_retire;
  logic [7:0]      r_ram [RAM_DEPTH];

  logic [RAM_AW-1:0] w_f;
  logic [7:0]        w_fval;
  logic              w_d;
  alu_op_t           w_alu_op;
  logic [7:0]        w_opa;
  logic              w_wr_w, w_wr_f, w_upd_z, w_upd_c, w_skip_op;
  logic              w_push, w_pop, w_jump;
  logic [8:0]        w_alu;
  logic [7:0]        w_res;
  logic              w_exec, w_fault;
  logic [PC_W-1:0]   w_tgt, w_stk_dout;
  logic              w_ovf, w_unf;

  assign w_f    = r_ir[RAM_AW-1:0];
  assign w_d    = r_ir[7];
  assign w_fval = r_ram[w_f];
  assign w_tgt  = PC_W'(r_ir[10:0]);
  assign w_exec = (r_state == ST_EXEC);

  always_comb begin
    w_alu_op  = ALU_PASS;
    w_opa     = r_ir[7:0];
    w_wr_w    = 1'b0;
    w_wr_f    = 1'b0;
    w_upd_z   = 1'b0;
    w_upd_c   = 1'b0;
    w_skip_op = 1'b0;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_jump    = 1'b0;
    if (r_ir[13:11] == OP3_GOTO) begin
      w_jump = 1'b1;
    end else if (r_ir[13:11] == OP3_CALL) begin
      w_jump = 1'b1;
      w_push = 1'b1;
    end else if (r_ir == INSN_RETURN) begin
      w_pop = 1'b1;
    end else if (r_ir[13:7] == OP7_MOVWF) begin
      w_opa  = r_w;
      w_wr_f = 1'b1;
    end else if (r_ir[13:7] == OP7_CLRW) begin
      w_alu_op = ALU_CLR; w_wr_w = 1'b1; w_upd_z = 1'b1;
    end else if (r_ir[13:7] == OP7_CLRF) begin
      w_alu_op = ALU_CLR; w_wr_f = 1'b1; w_upd_z = 1'b1;
    end else begin
      case (r_ir[13:8])
        OP_MOVLW: w_wr_w = 1'b1;
        OP_RETLW: begin w_wr_w = 1'b1; w_pop = 1'b1; end
        OP_ADDLW: begin w_alu_op = ALU_ADD; w_wr_w = 1'b1; w_upd_z = 1'b1; w_upd_c = 1'b1; end
        OP_SUBLW: begin w_alu_op = ALU_SUB; w_wr_w = 1'b1; w_upd_z = 1'b1; w_upd_c = 1'b1; end
        OP_ANDLW: begin w_alu_op = ALU_AND; w_wr_w = 1'b1; w_upd_z = 1'b1; end
        OP_IORLW: begin w_alu_op = ALU_IOR; w_wr_w = 1'b1; w_upd_z = 1'b1; end
        OP_XORLW: begin w_alu_op = ALU_XOR; w_wr_w = 1'b1; w_upd_z = 1'b1; end
        // File ops: operand is RAM[f], d selects W (0) or RAM[f] (1) as destination.
        OP_ADDWF: begin w_alu_op = ALU_ADD; w_opa = w_fval; w_wr_w = !w_d; w_wr_f = w_d; w_upd_z = 1'b1; w_upd_c = 1'b1; end
        OP_ANDWF: begin w_alu_op = ALU_AND; w_opa = w_fval; w_wr_w = !w_d; w_wr_f = w_d; w_upd_z = 1'b1; end
        OP_COMF:  begin w_alu_op = ALU_COM; w_opa = w_fval; w_wr_w = !w_d; w_wr_f = w_d; w_upd_z = 1'b1; end
        OP_DECF:  begin w_alu_op = ALU_DEC; w_opa = w_fval; w_wr_w = !w_d; w_wr_f = w_d; w_upd_z = 1'b1; end
        OP_INCF:  begin w_alu_op = ALU_INC; w_opa = w_fval; w_wr_w = !w_d; w_wr_f = w_d; w_upd_z = 1'b1; end
        OP_MOVF:  begin w_alu_op = ALU_PASS; w_opa = w_fval; w_wr_w = !w_d; w_wr_f = w_d; w_upd_z = 1'b1; end
        OP_DECFSZ: begin w_alu_op = ALU_DEC; w_opa = w_fval; w_wr_w = !w_d; w_wr_f = w_d; w_skip_op = 1'b1; end
        OP_INCFSZ: begin w_alu_op = ALU_INC; w_opa = w_fval; w_wr_w = !w_d; w_wr_f = w_d; w_skip_op = 1'b1; end
        default: ;
      endcase
    end
  end

  assign w_alu   = alu_eval(w_alu_op, w_opa, r_w);
  assign w_res   = w_alu[7:0];
  assign w_fault = w_ovf | w_unf;

  pic_call_stack #(
    .STACK_DEPTH (STACK_DEPTH),
    .PC_W        (PC_W)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (w_exec && w_push),
    .pop   (w_exec && w_pop),
    .din   (r_pc),
    .dout  (w_stk_dout),
    .ovf   (w_ovf),
    .unf   (w_unf)
  );

`ifdef PIC_CORE_STKERR_EN
  logic r_stk_err;
  logic r_halted;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stk_err <= 1'b0;
      r_halted  <= 1'b0;
    end else if (w_exec && w_fault) begin
      r_stk_err <= 1'b1;
      r_halted  <= 1'b1;
    end
  end
  assign pbus.stk_err = r_stk_err;
  assign pbus.halted  = r_halted;
`else
  assign pbus.stk_err = 1'b0;
  assign pbus.halted  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_FETCH;
      r_pc     <= '0;
      r_ir     <= '0;
      r_w      <= '0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_retire <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          r_ir     <= pbus.imem_data;
          r_pc     <= r_pc + PC_W'(1);
          r_retire <= 1'b1;
          r_state  <= ST_EXEC;
        end
        ST_EXEC: begin
          r_retire <= 1'b0;
          r_state  <= ST_FETCH;
          if (!w_fault) begin
            if (w_wr_w)  r_w <= w_res;
            if (w_upd_z) r_z <= (w_res == 8'd0);
            if (w_upd_c) r_c <= w_alu[8];
            if (w_jump)
              r_pc <= w_tgt;
            else if (w_pop)
              r_pc <= w_stk_dout;
            else if (w_skip_op && (w_res == 8'd0))
              r_pc <= r_pc + PC_W'(1);
          end
`ifdef PIC_CORE_STKERR_EN
          if (w_fault) r_state <= ST_HALT;
`endif
        end
        ST_HALT: r_retire <= 1'b0;
        default: begin
          r_retire <= 1'b0;
          r_state  <= ST_FETCH;
        end
      endcase
    end
  end

  // State is forced to FETCH by reset, so an aborted EXEC never writes RAM.
  always_ff @(posedge clk) begin
    if (w_exec && !w_fault && w_wr_f) begin
      r_ram[w_f] <= w_res;
    end
  end

  assign pbus.imem_addr = r_pc;
  assign pbus.w_q_out   = r_w;
  assign pbus.status_z  = r_z;
  assign pbus.status_c  = r_c;
  assign pbus.retire    = r_retire;

endmodule

`default_nettype wire

// File: tb/tb_pic_core_stack.sv
// tb_pic_core_stack: table-driven instruction vectors plus hand-written multi-cycle sequences.
`default_nettype none

module tb_pic_core_stack;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic [13:0] rom [2048];

  pic_core_stack_if #(.PC_W(11)) pbus ();
  assign pbus.imem_data = rom[pbus.imem_addr];

  pic_core_stack #(.PC_W(11), .RAM_AW(7), .STACK_DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .pbus  (pbus.core)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] p0, p1, p2, p3;
    logic [7:0]  w;
    logic        z, c;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic [13:0] a, b, c2, d, input logic [7:0] w, input logic z, c);
    vec_t v;
    v.p0 = a; v.p1 = b; v.p2 = c2; v.p3 = d; v.w = w; v.z = z; v.c = c;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 2048; i++) rom[i] = 14'h0000;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] rpat;
    logic [10:0] held;

    // {p0,p1,p2,p3} then expected W, Z, C; addr 4 holds GOTO 4.
    add(14'h30A5, 14'h3E5B, 14'h0000, 14'h0000, 8'h00, 1'b1, 1'b1);
    add(14'h3005, 14'h3C03, 14'h0000, 14'h0000, 8'hFE, 1'b0, 1'b0);
    add(14'h3003, 14'h3C05, 14'h0000, 14'h0000, 8'h02, 1'b0, 1'b1);
    add(14'h3003, 14'h3C03, 14'h0000, 14'h0000, 8'h00, 1'b1, 1'b1);
    add(14'h30F0, 14'h393C, 14'h0000, 14'h0000, 8'h30, 1'b0, 1'b0);
    add(14'h30F0, 14'h380F, 14'h0000, 14'h0000, 8'hFF, 1'b0, 1'b0);
    add(14'h30FF, 14'h3AFF, 14'h0000, 14'h0000, 8'h00, 1'b1, 1'b0);
    add(14'h3042, 14'h0090, 14'h0A10, 14'h0000, 8'h43, 1'b0, 1'b0);
    add(14'h30FF, 14'h0091, 14'h0A11, 14'h0000, 8'h00, 1'b1, 1'b0);
    add(14'h3080, 14'h0092, 14'h0712, 14'h0000, 8'h00, 1'b1, 1'b1);
    add(14'h305A, 14'h0093, 14'h0913, 14'h0000, 8'hA5, 1'b0, 1'b0);
    add(14'h3001, 14'h0094, 14'h0314, 14'h0000, 8'h00, 1'b1, 1'b0);
    add(14'h3007, 14'h0100, 14'h0000, 14'h0000, 8'h00, 1'b1, 1'b0);
    add(14'h3033, 14'h0096, 14'h3000, 14'h0000, 8'h00, 1'b0, 1'b0);
    add(14'h3009, 14'h0097, 14'h0A97, 14'h0817, 8'h0A, 1'b0, 1'b0);
    add(14'h3001, 14'h0098, 14'h0B98, 14'h3077, 8'h01, 1'b0, 1'b0);
    add(14'h3005, 14'h0099, 14'h0F99, 14'h3077, 8'h77, 1'b0, 1'b0);
    add(14'h300F, 14'h009A, 14'h303C, 14'h059A, 8'h3C, 1'b0, 1'b0);
    add(14'h3012, 14'h3F34, 14'h0064, 14'h0000, 8'h12, 1'b0, 1'b0);
    add(14'h3066, 14'h0085, 14'h0100, 14'h0805, 8'h66, 1'b0, 1'b0);
    add(14'h3066, 14'h0085, 14'h0185, 14'h0000, 8'h66, 1'b1, 1'b0);
    add(14'h3009, 14'h0805, 14'h0000, 14'h0000, 8'h00, 1'b1, 1'b0);

    clear_rom();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_addr", 32'(pbus.imem_addr), 32'h0);
    check("rst_wzc", {22'd0, pbus.w_q_out, pbus.status_z, pbus.status_c}, 32'h0);
    check("rst_retire", 32'(pbus.retire), 32'h0);
    check("rst_err_halt", {30'd0, pbus.stk_err, pbus.halted}, 32'h0);

    // retire alternates 1,0 starting with the first EXEC.
    rom[0] = 14'h2800;
    reset = 1'b1;
    rpat = '0;
    for (int i = 0; i < 10; i++) begin
      run(1);
      rpat = {rpat[8:0], pbus.retire};
    end
    check("retire_pattern", 32'(rpat), 32'h2AA);

    foreach (vq[i]) begin
      clear_rom();
      rom[0] = vq[i].p0; rom[1] = vq[i].p1; rom[2] = vq[i].p2; rom[3] = vq[i].p3;
      rom[4] = 14'h2804;
      do_reset();
      run(10);
      check($sformatf("vec%0d_wzc", i),
            {22'd0, pbus.w_q_out, pbus.status_z, pbus.status_c},
            {22'd0, vq[i].w, vq[i].z, vq[i].c});
    end

    // DECFSZ loop with pass counter in RAM[0x20].
    clear_rom();
    rom[0] = 14'h01A0; rom[1] = 14'h3003; rom[2] = 14'h0090; rom[3] = 14'h0FA0;
    rom[4] = 14'h0B90; rom[5] = 14'h2803; rom[6] = 14'h2806;
    do_reset();
    run(40);
    check("loop_wzc", {22'd0, pbus.w_q_out, pbus.status_z, pbus.status_c}, {22'd0, 8'h03, 1'b1, 1'b0});
    clear_rom();
    rom[0] = 14'h0810; rom[1] = 14'h2801;
    do_reset();
    run(6);
    check("loop_ram10", {23'd0, pbus.w_q_out, pbus.status_z}, {23'd0, 8'h00, 1'b1});
    rom[0] = 14'h0820;
    do_reset();
    run(6);
    check("loop_passes", 32'(pbus.w_q_out), 32'h03);

    // CALL 0x20 / RETLW 0x7E, cycle by cycle.
    clear_rom();
    rom[0] = 14'h2020; rom[1] = 14'h2801; rom[12'h20] = 14'h347E;
    do_reset();
    run(1);
    check("call_fetch", {20'd0, pbus.retire, pbus.imem_addr}, {20'd0, 1'b1, 11'h001});
    run(1);
    check("call_jump", {20'd0, pbus.retire, pbus.imem_addr}, {20'd0, 1'b0, 11'h020});
    run(2);
    check("retlw_ret", {13'd0, pbus.w_q_out, pbus.imem_addr}, {13'd0, 8'h7E, 11'h001});

    // Eight nested calls unwind fully in either build.
    clear_rom();
    rom[0] = 14'h2040; rom[1] = 14'h3011; rom[2] = 14'h2802;
    for (int i = 0; i < 7; i++) begin
      rom[12'h40 + 2*i] = 14'h2000 | 14'(12'h42 + 2*i);
      rom[12'h41 + 2*i] = 14'h0008;
    end
    rom[12'h4E] = 14'h0008;
    do_reset();
    run(60);
    check("nest8_w", {30'd0, pbus.stk_err, pbus.halted} | {pbus.w_q_out, 24'd0}, {8'h11, 24'd0});

    // Nine nested calls: one more than the stack holds.
    rom[12'h4E] = 14'h2050; rom[12'h4F] = 14'h0008; rom[12'h50] = 14'h0008;
    do_reset();
    run(60);
`ifdef PIC_CORE_STKERR_EN
    check("ovf_flags", {30'd0, pbus.stk_err, pbus.halted}, 32'h3);
    check("ovf_pc", 32'(pbus.imem_addr), 32'h04F);
    held = pbus.imem_addr;
    rpat = '0;
    for (int i = 0; i < 4; i++) begin
      run(1);
      rpat = {rpat[8:0], pbus.retire};
    end
    check("halt_frozen", {20'd0, rpat[0] | rpat[1] | rpat[2] | rpat[3], pbus.imem_addr}, {20'd0, 1'b0, held});
    do_reset();
    check("halt_cleared", {30'd0, pbus.stk_err, pbus.halted}, 32'h0);
`else
    check("wrap_noflag", {30'd0, pbus.stk_err, pbus.halted}, 32'h0);
    check("wrap_lost_ret", 32'(pbus.w_q_out), 32'h00);
`endif

    // Reset mid-EXEC of MOVWF 0x21 must not write RAM.
    clear_rom();
    rom[0] = 14'h3055; rom[1] = 14'h00A1; rom[2] = 14'h3EAC; rom[3] = 14'h00A1; rom[4] = 14'h2804;
    do_reset();
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("pre_abort_wc", {23'd0, pbus.w_q_out, pbus.status_c}, {23'd0, 8'h01, 1'b1});
    reset = 1'b0;
    #1;
    check("abort_state", {9'd0, pbus.imem_addr, pbus.w_q_out, pbus.status_z, pbus.status_c, pbus.retire},
          32'h0);
    repeat (2) @(posedge clk);
    rom[0] = 14'h0821; rom[1] = 14'h2801;
    @(negedge clk);
    reset = 1'b1;
    run(4);
    check("abort_ram21", 32'(pbus.w_q_out), 32'h55);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
